// File: rtl/irq_dispatch.sv
// irq_dispatch: interrupt front end for the SM83 core.
// Holds IF/IE and the IME state machine (EI delay, DI, RETI), presents a
// registered interrupt request and a HALT wake signal to the Sequencer, and
// resolves priority / latches the RST vector on the Sequencer's acknowledge.
// Optional feature macro: IRQ_HALT_BUG_EN enables the HALT-bug detector;
// without it HALT_BUG is tied low.
module irq_dispatch #(
    parameter int NUM_IRQ = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               REG_SEL,
    input  logic               REG_WR,
    input  logic [7:0]         DIN,
    output logic [7:0]         DOUT,
    input  logic               M1,
    input  logic               OP_EI,
    input  logic               OP_DI,
    input  logic               OP_RETI,
    input  logic               OP_HALT,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic               WAKE,
    output logic               IME,
    output logic [7:0]         VECTOR,
    output logic               HALT_BUG
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_PEND = 2'd1,
        ST_ON   = 2'd2
    } ime_state_t;

    ime_state_t         state;
    ime_state_t         state_next;

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_next;
    logic [7:0]         ie_q;
    logic [NUM_IRQ-1:0] pend;
    logic               pend_any;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [7:0]         ack_vector;
    logic [7:0]         if_view;

    logic               int_req_q;
    logic               wake_q;
    logic [7:0]         vector_q;

    // Index of the highest-priority (lowest-numbered) set bit; 0 if none.
    function automatic logic [2:0] lowest_index(input logic [NUM_IRQ-1:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (m[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // One-hot mask of the lowest set bit, all zero when nothing is set.
    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] m);
        logic [NUM_IRQ-1:0] oh;
        oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (m[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // RST target low byte: 0x40 + 8*n, or 0x00 when the request evaporated.
    function automatic logic [7:0] rst_vector(input logic any, input logic [2:0] idx);
        return any ? (8'h40 + {2'b00, idx, 3'b000}) : 8'h00;
    endfunction

    assign pend       = ie_q[NUM_IRQ-1:0] & if_q;
    assign pend_any   = |pend;
    assign ack_clr    = lowest_onehot(pend);
    assign ack_vector = rst_vector(pend_any, lowest_index(pend));

    // IME next state; acknowledge beats DI beats RETI beats EI.
    always_comb begin
        state_next = state;
        if (INT_ACK) begin
            state_next = ST_OFF;
        end else if (OP_DI) begin
            state_next = ST_OFF;
        end else if (OP_RETI) begin
            state_next = ST_ON;
        end else if (OP_EI) begin
            // An EI strobe never counts as "after itself": a coincident M1
            // does not complete the enable.
            if (state == ST_OFF) state_next = ST_PEND;
        end else if (state == ST_PEND && M1) begin
            state_next = ST_ON;
        end else if (state != ST_OFF && state != ST_PEND && state != ST_ON) begin
            state_next = ST_OFF;
        end
    end

    // IME state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_OFF;
        else       state <= state_next;
    end

    // IF next value: CPU write, then ack clear on top, then IRQ set on top,
    // so a peripheral pulse is never lost to a same-cycle clear or write.
    always_comb begin
        if_next = if_q;
        if (REG_WR && !REG_SEL) if_next = DIN[NUM_IRQ-1:0];
        if (INT_ACK)            if_next = if_next & ~ack_clr;
        if_next = if_next | IRQ;
    end

    // IF and IE storage.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            if_q <= '0;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_next;
            if (REG_WR && REG_SEL) ie_q <= DIN;
        end
    end

    // Registered request/wake; the request is withdrawn as soon as the
    // Sequencer acknowledges so it cannot be taken twice.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            int_req_q <= 1'b0;
            wake_q    <= 1'b0;
        end else begin
            int_req_q <= (state == ST_ON) && pend_any && !INT_ACK;
            wake_q    <= pend_any;
        end
    end

    // Dispatch vector latch, held until the next acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        vector_q <= 8'h00;
        else if (INT_ACK) vector_q <= ack_vector;
    end

    // Register readback; unimplemented IF bits read as 1.
    always_comb begin
        if_view              = 8'hFF;
        if_view[NUM_IRQ-1:0] = if_q;
        DOUT                 = REG_SEL ? ie_q : if_view;
    end

`ifdef IRQ_HALT_BUG_EN
    logic halt_bug_q;

    // HALT with IME clear and something pending: one-cycle HALT-bug pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) halt_bug_q <= 1'b0;
        else       halt_bug_q <= OP_HALT && (state != ST_ON) && pend_any;
    end

    assign HALT_BUG = halt_bug_q;
`else
    logic unused_halt;
    assign unused_halt = OP_HALT;
    assign HALT_BUG    = 1'b0;
`endif

    assign INT_REQ = int_req_q;
    assign WAKE    = wake_q;
    assign IME     = (state == ST_ON);
    assign VECTOR  = vector_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch: reset state, wake/request latency, EI
// delay, dispatch priority, empty acknowledge, IRQ-vs-clear races, DI/RETI
// priority, HALT bug and asynchronous reset during dispatch.
module tb_irq_dispatch;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] IRQ;
    logic       REG_SEL;
    logic       REG_WR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       M1;
    logic       OP_EI;
    logic       OP_DI;
    logic       OP_RETI;
    logic       OP_HALT;
    logic       INT_ACK;
    logic       INT_REQ;
    logic       WAKE;
    logic       IME;
    logic [7:0] VECTOR;
    logic       HALT_BUG;

    int n_cmp  = 0;
    int n_fail = 0;

    irq_dispatch #(.NUM_IRQ(5)) dut (
        .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .REG_SEL(REG_SEL), .REG_WR(REG_WR),
        .DIN(DIN), .DOUT(DOUT), .M1(M1), .OP_EI(OP_EI), .OP_DI(OP_DI),
        .OP_RETI(OP_RETI), .OP_HALT(OP_HALT), .INT_ACK(INT_ACK),
        .INT_REQ(INT_REQ), .WAKE(WAKE), .IME(IME), .VECTOR(VECTOR),
        .HALT_BUG(HALT_BUG)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        IRQ = 5'd0; REG_SEL = 1'b0; REG_WR = 1'b0; DIN = 8'h00; M1 = 1'b0;
        OP_EI = 1'b0; OP_DI = 1'b0; OP_RETI = 1'b0; OP_HALT = 1'b0; INT_ACK = 1'b0;
    endtask

    // One clock: inputs were set before the call, outputs settle #1 after
    // the edge, then all strobes return to idle.
    task automatic step();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic write_reg(input logic sel, input logic [7:0] d);
        REG_SEL = sel; REG_WR = 1'b1; DIN = d;
        step();
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        step();
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hE0) begin n_fail++; $display("FAIL rst_if: got %h want e0", DOUT); end
        REG_SEL = 1'b1; #1;
        n_cmp++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL rst_ie: got %h want 00", DOUT); end
        REG_SEL = 1'b0;
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_int_req: got %b want 0", INT_REQ); end
        n_cmp++; if (WAKE !== 1'b0) begin n_fail++; $display("FAIL rst_wake: got %b want 0", WAKE); end
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL rst_ime: got %b want 0", IME); end
        n_cmp++; if (VECTOR !== 8'h00) begin n_fail++; $display("FAIL rst_vector: got %h want 00", VECTOR); end
        n_cmp++; if (HALT_BUG !== 1'b0) begin n_fail++; $display("FAIL rst_halt_bug: got %b want 0", HALT_BUG); end
    endtask

    task automatic test_wake();
        write_reg(1'b1, 8'h1F);
        IRQ = 5'b00100;
        step();
        n_cmp++; if (WAKE !== 1'b0) begin n_fail++; $display("FAIL wake_lat1: got %b want 0", WAKE); end
        step();
        n_cmp++; if (WAKE !== 1'b1) begin n_fail++; $display("FAIL wake_lat2: got %b want 1", WAKE); end
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL wake_no_req: got %b want 0", INT_REQ); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hE4) begin n_fail++; $display("FAIL wake_if_read: got %h want e4", DOUT); end
        write_reg(1'b0, 8'h00);
        step();
        n_cmp++; if (WAKE !== 1'b0) begin n_fail++; $display("FAIL wake_clear: got %b want 0", WAKE); end
    endtask

    task automatic test_ei_delay();
        OP_EI = 1'b1; M1 = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL ei_same_m1: got %b want 0", IME); end
        IRQ = 5'b00001;
        step();
        step();
        n_cmp++; if (WAKE !== 1'b1) begin n_fail++; $display("FAIL ei_wake: got %b want 1", WAKE); end
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL ei_pend_req: got %b want 0", INT_REQ); end
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL ei_pend_ime: got %b want 0", IME); end
        M1 = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b1) begin n_fail++; $display("FAIL ei_on_ime: got %b want 1", IME); end
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL ei_on_req0: got %b want 0", INT_REQ); end
        step();
        n_cmp++; if (INT_REQ !== 1'b1) begin n_fail++; $display("FAIL ei_on_req1: got %b want 1", INT_REQ); end
    endtask

    task automatic test_dispatch();
        write_reg(1'b0, 8'h1F);
        INT_ACK = 1'b1;
        step();
        n_cmp++; if (VECTOR !== 8'h40) begin n_fail++; $display("FAIL disp_vec0: got %h want 40", VECTOR); end
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL disp_ime: got %b want 0", IME); end
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL disp_req_drop: got %b want 0", INT_REQ); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hFE) begin n_fail++; $display("FAIL disp_if0: got %h want fe", DOUT); end
        OP_RETI = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b1) begin n_fail++; $display("FAIL disp_reti: got %b want 1", IME); end
        INT_ACK = 1'b1;
        step();
        n_cmp++; if (VECTOR !== 8'h48) begin n_fail++; $display("FAIL disp_vec1: got %h want 48", VECTOR); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hFC) begin n_fail++; $display("FAIL disp_if1: got %h want fc", DOUT); end
    endtask

    task automatic test_ack_empty();
        write_reg(1'b1, 8'h00);
        INT_ACK = 1'b1;
        step();
        n_cmp++; if (VECTOR !== 8'h00) begin n_fail++; $display("FAIL empty_vec: got %h want 00", VECTOR); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hFC) begin n_fail++; $display("FAIL empty_if: got %h want fc", DOUT); end
        write_reg(1'b1, 8'h1F);
        OP_RETI = 1'b1; INT_ACK = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL ack_over_reti: got %b want 0", IME); end
        n_cmp++; if (VECTOR !== 8'h50) begin n_fail++; $display("FAIL vec_bit2: got %h want 50", VECTOR); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hF8) begin n_fail++; $display("FAIL if_bit2_clr: got %h want f8", DOUT); end
    endtask

    task automatic test_irq_race();
        INT_ACK = 1'b1; IRQ = 5'b01000;
        step();
        n_cmp++; if (VECTOR !== 8'h58) begin n_fail++; $display("FAIL race_vec: got %h want 58", VECTOR); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hF8) begin n_fail++; $display("FAIL race_ack_irq: got %h want f8", DOUT); end
        IRQ = 5'b10000;
        write_reg(1'b0, 8'h00);
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hF0) begin n_fail++; $display("FAIL race_wr_irq: got %h want f0", DOUT); end
    endtask

    task automatic test_di_priority();
        OP_EI = 1'b1;
        step();
        OP_DI = 1'b1;
        step();
        M1 = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL di_cancel: got %b want 0", IME); end
        OP_RETI = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b1) begin n_fail++; $display("FAIL reti_on: got %b want 1", IME); end
        OP_DI = 1'b1; OP_RETI = 1'b1;
        step();
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL di_over_reti: got %b want 0", IME); end
    endtask

    task automatic test_halt_bug();
        logic exp_pulse;
`ifdef IRQ_HALT_BUG_EN
        exp_pulse = 1'b1;
`else
        exp_pulse = 1'b0;
`endif
        OP_HALT = 1'b1;
        step();
        n_cmp++; if (HALT_BUG !== exp_pulse) begin n_fail++; $display("FAIL halt_pulse: got %b want %b", HALT_BUG, exp_pulse); end
        step();
        n_cmp++; if (HALT_BUG !== 1'b0) begin n_fail++; $display("FAIL halt_one_cycle: got %b want 0", HALT_BUG); end
        OP_RETI = 1'b1;
        step();
        OP_HALT = 1'b1;
        step();
        n_cmp++; if (HALT_BUG !== 1'b0) begin n_fail++; $display("FAIL halt_ime_on: got %b want 0", HALT_BUG); end
    endtask

    task automatic test_reset_mid_dispatch();
        INT_ACK = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        n_cmp++; if (VECTOR !== 8'h00) begin n_fail++; $display("FAIL arst_vector: got %h want 00", VECTOR); end
        n_cmp++; if (IME !== 1'b0) begin n_fail++; $display("FAIL arst_ime: got %b want 0", IME); end
        n_cmp++; if (INT_REQ !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b want 0", INT_REQ); end
        step();
        RESET = 1'b0;
        step();
        n_cmp++; if (VECTOR !== 8'h00) begin n_fail++; $display("FAIL arst_vec_hold: got %h want 00", VECTOR); end
        REG_SEL = 1'b0; #1;
        n_cmp++; if (DOUT !== 8'hE0) begin n_fail++; $display("FAIL arst_if: got %h want e0", DOUT); end
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        test_reset();
        test_wake();
        test_ei_delay();
        test_dispatch();
        test_ack_empty();
        test_irq_race();
        test_di_priority();
        test_halt_bug();
        test_reset_mid_dispatch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
